// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel receiver with comma-based byte alignment and lock detection.
// Bytes arrive MSB first. After lock, non-comma and non-idle bytes are presented on data_out.
module serial_paralelo_rx #(
    parameter logic [7:0]  COM          = 8'hBC,
    parameter logic [7:0]  IDL          = 8'h7C,
    parameter int unsigned ACTIVE_COUNT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active,
    output logic       byte_strobe
);

    typedef enum logic [1:0] {StSearch, StAligned, StActive} state_e;

    localparam logic [2:0] ActiveCnt = 3'(ACTIVE_COUNT);

    state_e     state_q, state_d;
    // Only seven bits of history are needed: the eighth bit is the live input.
    logic [6:0] shift_q;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [2:0] com_cnt_q, com_cnt_d;
    logic [7:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       active_q, active_d;
    logic       strobe_q, strobe_d;
    logic [7:0] window;
    logic       boundary;

    assign window   = {shift_q, data_in};
    assign boundary = (bit_cnt_q == 3'd7);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        com_cnt_d = com_cnt_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        strobe_d  = 1'b0;
        active_d  = active_q;

        unique case (state_q)
            StSearch: begin
                if (window == COM) begin
                    bit_cnt_d = 3'd0;
                    com_cnt_d = 3'd1;
                    if (ACTIVE_COUNT > 1) begin
                        state_d = StAligned;
                    end else begin
                        state_d  = StActive;
                        active_d = 1'b1;
                    end
                end
            end
            StAligned: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (boundary) begin
                    if (window == COM) begin
                        com_cnt_d = com_cnt_q + 3'd1;
                        if (com_cnt_d == ActiveCnt) begin
                            state_d  = StActive;
                            active_d = 1'b1;
                        end
                    end else begin
                        // Lost alignment; the next COM match is evaluated on the following edge.
                        state_d   = StSearch;
                        com_cnt_d = 3'd0;
                    end
                end
            end
            StActive: begin
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (boundary) begin
                    strobe_d = 1'b1;
                    if (window != COM && window != IDL) begin
                        data_d  = window;
                        valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StSearch;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StSearch;
            shift_q   <= 7'd0;
            bit_cnt_q <= 3'd0;
            com_cnt_q <= 3'd0;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            active_q  <= 1'b0;
            strobe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= window[6:0];
            bit_cnt_q <= bit_cnt_d;
            com_cnt_q <= com_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            active_q  <= active_d;
            strobe_q  <= strobe_d;
        end
    end

    assign data_out    = data_q;
    assign valid_out   = valid_q;
    assign active      = active_q;
    assign byte_strobe = strobe_q;

endmodule

// File: doc/serial_paralelo_rx.md
SERIAL_PARALELO_RX -- requirements
Module: serial_paralelo_rx

Interface
REQ-001 Parameter COM, default 8'hBC: comma symbol used for byte alignment.
REQ-002 Parameter IDL, default 8'h7C: idle symbol; never reported as valid data.
REQ-003 Parameter ACTIVE_COUNT, default 4, legal range 1..7: number of aligned COM bytes required to declare lock.
REQ-004 clk  input  1  serial bit clock; all state changes on the rising edge; one clock only.
REQ-005 reset  input  1  asynchronous, active-low; reset=0 forces the reset state immediately, independent of clk.
REQ-006 data_in  input  1  serial bit stream, MSB of each byte first, sampled on every rising edge of clk.
REQ-007 data_out  output  8  last valid received byte, registered.
REQ-008 valid_out  output  1  one-cycle pulse: data_out was loaded with a new valid byte on this edge.
REQ-009 active  output  1  lock indicator, registered.
REQ-010 byte_strobe  output  1  one-cycle pulse at every byte boundary while locked.

Function
REQ-011 The block SHALL form window = {shift[6:0], data_in} each edge, then load shift <= window.
REQ-012 The block SHALL use three states: SEARCH, ALIGNED and ACTIVE, plus bit_cnt (3 bit) and com_cnt (3 bit).
REQ-013 SEARCH: if window == COM at edge k, bit_cnt <= 0 and com_cnt <= 1; go to ALIGNED if ACTIVE_COUNT > 1, else go to ACTIVE with active <= 1. Otherwise stay in SEARCH.
REQ-014 ALIGNED/ACTIVE: bit_cnt increments every edge and wraps 7->0; the edge where bit_cnt == 7 is a byte boundary and byte = window.
REQ-015 ALIGNED boundary with byte == COM: com_cnt increments; if the new value equals ACTIVE_COUNT, go to ACTIVE and set active <= 1 on that same edge.
REQ-016 ALIGNED boundary with byte != COM: go to SEARCH and set com_cnt <= 0. No COM match is evaluated on that edge; search resumes on the next edge.
REQ-017 ACTIVE boundary: byte_strobe <= 1.
- byte == COM or byte == IDL: valid_out <= 0 and data_out is held.
- any other byte: data_out <= byte and valid_out <= 1.
REQ-018 valid_out and byte_strobe SHALL be 0 on every non-boundary edge and in SEARCH and ALIGNED.
REQ-019 Latency: the last bit of a byte sampled at edge k SHALL appear on data_out/valid_out/byte_strobe immediately after edge k.
REQ-020 active SHALL be sticky: once in ACTIVE, the block remains there until reset; no loss-of-lock detection.
REQ-021 Bit ordering SHALL be MSB-first: the first bit of a byte lands in window[7] at the boundary.

Reset
REQ-022 While reset == 0, all outputs and internal state SHALL be held at reset values:
- state = SEARCH
- shift = 0, bit_cnt = 0, com_cnt = 0
- data_out = 8'h00, valid_out = 0, active = 0, byte_strobe = 0
REQ-023 Reset asserted mid-byte or while ACTIVE SHALL abort immediately. After release, alignment restarts from SEARCH with no retained partial byte.

Verification
REQ-024 Lock: after reset release, send BC,BC,BC,BC.
- active rises right after the 32nd bit edge.
- valid_out stays 0 throughout.
REQ-025 Data: locked, then send A5,3C.
- valid_out pulses with data_out = A5 at bit 8.
- valid_out pulses with data_out = 3C at bit 16.
- byte_strobe pulses at both boundaries.
REQ-026 Filtering: locked, then send 7C,BC,5A.
- byte_strobe pulses 3 times.
- valid_out pulses once, with data_out = 5A.
- data_out holds its previous value during 7C and BC.
REQ-027 Misalignment: send 3 junk bits 1,0,1, then BC x4, then 11.
- Lock is achieved.
- data_out = 11 with a valid_out pulse.
REQ-028 Broken lock: send BC,BC,00, then BC x4.
- active stays 0 through the 00 byte (return to SEARCH).
- active rises after the subsequent 4 COMs.
REQ-029 Reset mid-operation: assert reset=0 for 3 edges while ACTIVE in the middle of a byte.
- All outputs clear immediately, without waiting for a clock edge.
- After release, 4 new COMs are required before active rises.
